// File: rtl/easyaxi_rd_slice.sv
// Registered AR/R read-path slice: one 2-entry skid buffer per channel, no input-to-output comb paths.
// Optional outstanding-burst limiter enabled by defining EASYAXI_RD_SLICE_OST_LIMIT_EN.

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_USER_W
`define AXI_USER_W 1
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module easyaxi_rd_slice_skid #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic         in_en,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         main_vld;
    logic [W-1:0] main_dat;
    logic         skid_full;
    logic [W-1:0] skid_dat;
    logic         in_hs;
    logic         out_hs;

    // in_en lets the parent gate acceptance (e.g. the outstanding limiter)
    assign in_hs     = in_valid & ~skid_full & in_en;
    assign out_hs    = main_vld & out_ready;
    assign in_ready  = ~skid_full;
    assign out_valid = main_vld;
    assign out_data  = main_dat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_vld  <= 1'b0;
            main_dat  <= '0;
            skid_full <= 1'b0;
            skid_dat  <= '0;
        end else if (!main_vld || out_hs) begin
            if (skid_full) begin
                main_vld <= 1'b1;
                main_dat <= skid_dat;
                if (in_hs) skid_dat <= in_data;
                else       skid_full <= 1'b0;
            end else begin
                main_vld <= in_hs;
                if (in_hs) main_dat <= in_data;
            end
        end else if (in_hs) begin
            skid_dat  <= in_data;
            skid_full <= 1'b1;
        end
    end
endmodule

module easyaxi_rd_slice #(
    parameter int MAX_OST = 8,
    parameter int OST_W   = $clog2(MAX_OST + 1),
    parameter int ARW     = `AXI_ID_W + `AXI_ADDR_W + `AXI_LEN_W + `AXI_SIZE_W + `AXI_BURST_W + `AXI_USER_W,
    parameter int RW      = `AXI_ID_W + `AXI_DATA_W + `AXI_RESP_W + `AXI_USER_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_arvalid,
    output logic             up_arready,
    input  logic [ARW-1:0]   up_arpld,
    output logic             dn_arvalid,
    input  logic             dn_arready,
    output logic [ARW-1:0]   dn_arpld,
    input  logic             dn_rvalid,
    output logic             dn_rready,
    input  logic [RW-1:0]    dn_rpld,
    input  logic             dn_rlast,
    output logic             up_rvalid,
    input  logic             up_rready,
    output logic [RW-1:0]    up_rpld,
    output logic             up_rlast,
    output logic [OST_W-1:0] ost_cnt
);
    logic ar_rdy;
    logic lim_ok;

    easyaxi_rd_slice_skid #(.W(ARW)) u_ar (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (up_arvalid),
        .in_en     (lim_ok),
        .in_ready  (ar_rdy),
        .in_data   (up_arpld),
        .out_valid (dn_arvalid),
        .out_ready (dn_arready),
        .out_data  (dn_arpld)
    );

    // rlast rides in the top bit of the R skid word so it stays with its beat
    easyaxi_rd_slice_skid #(.W(RW + 1)) u_r (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (dn_rvalid),
        .in_en     (1'b1),
        .in_ready  (dn_rready),
        .in_data   ({dn_rlast, dn_rpld}),
        .out_valid (up_rvalid),
        .out_ready (up_rready),
        .out_data  ({up_rlast, up_rpld})
    );

    assign up_arready = ar_rdy & lim_ok;

`ifdef EASYAXI_RD_SLICE_OST_LIMIT_EN
    logic ost_inc;
    logic ost_dec;

    assign lim_ok  = (ost_cnt < OST_W'(MAX_OST));
    assign ost_inc = up_arvalid & up_arready;
    assign ost_dec = dn_rvalid & dn_rready & dn_rlast;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ost_cnt <= '0;
        end else if (ost_inc && !ost_dec) begin
            ost_cnt <= ost_cnt + 1'b1;
        end else if (ost_dec && !ost_inc && ost_cnt != '0) begin
            ost_cnt <= ost_cnt - 1'b1;
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(ost_dec && !ost_inc && ost_cnt == '0));
`else
    assign lim_ok  = 1'b1;
    assign ost_cnt = '0;
`endif
endmodule

// File: tb/tb_easyaxi_rd_slice.sv
// Directed bench for easyaxi_rd_slice: latency, streaming, backpressure, R burst stall, limiter, reset.

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_USER_W
`define AXI_USER_W 1
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module tb_easyaxi_rd_slice;
    localparam int MAX_OST = 2;
    localparam int OST_W   = $clog2(MAX_OST + 1);
    localparam int ARW = `AXI_ID_W + `AXI_ADDR_W + `AXI_LEN_W + `AXI_SIZE_W + `AXI_BURST_W + `AXI_USER_W;
    localparam int RW  = `AXI_ID_W + `AXI_DATA_W + `AXI_RESP_W + `AXI_USER_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             up_arvalid, up_arready;
    logic [ARW-1:0]   up_arpld, dn_arpld;
    logic             dn_arvalid, dn_arready;
    logic             dn_rvalid, dn_rready, dn_rlast;
    logic [RW-1:0]    dn_rpld, up_rpld;
    logic             up_rvalid, up_rready, up_rlast;
    logic [OST_W-1:0] ost_cnt;

    int vectors = 0;
    int errs    = 0;

    easyaxi_rd_slice #(.MAX_OST(MAX_OST)) dut (
        .clk(clk), .rst_n(rst_n),
        .up_arvalid(up_arvalid), .up_arready(up_arready), .up_arpld(up_arpld),
        .dn_arvalid(dn_arvalid), .dn_arready(dn_arready), .dn_arpld(dn_arpld),
        .dn_rvalid(dn_rvalid), .dn_rready(dn_rready), .dn_rpld(dn_rpld), .dn_rlast(dn_rlast),
        .up_rvalid(up_rvalid), .up_rready(up_rready), .up_rpld(up_rpld), .up_rlast(up_rlast),
        .ost_cnt(ost_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ARW-1:0] ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        return {id, addr, len, 3'd2, 2'd1, 1'b0};
    endfunction

    function automatic logic [RW-1:0] rb(input logic [3:0] id, input logic [31:0] data);
        return {id, data, 2'b00, 1'b0};
    endfunction

    initial begin
        rst_n = 1'b0; up_arvalid = 1'b0; up_arpld = '0; dn_arready = 1'b1;
        dn_rvalid = 1'b0; dn_rpld = '0; dn_rlast = 1'b0; up_rready = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_dn_arvalid", 64'(dn_arvalid), 64'd0);
        check("rst_up_rvalid", 64'(up_rvalid), 64'd0);
        check("rst_up_arready", 64'(up_arready), 64'd1);
        check("rst_dn_rready", 64'(dn_rready), 64'd1);
        check("rst_ost_cnt", 64'(ost_cnt), 64'd0);
        check("rst_dn_arpld", 64'(dn_arpld), 64'd0);

        // single AR then single R beat
        up_arvalid = 1'b1; up_arpld = ar(4'd3, 32'h100, 8'd0);
        check("t1_arready", 64'(up_arready), 64'd1);
        tick();
        up_arvalid = 1'b0;
        check("t1_dn_arvalid", 64'(dn_arvalid), 64'd1);
        check("t1_dn_arpld", 64'(dn_arpld), 64'(ar(4'd3, 32'h100, 8'd0)));
        check("t1_ost_after_ar", 64'(ost_cnt),
`ifdef EASYAXI_RD_SLICE_OST_LIMIT_EN
              64'd1);
`else
              64'd0);
`endif
        tick();
        check("t1_dn_arvalid_drop", 64'(dn_arvalid), 64'd0);
        dn_rvalid = 1'b1; dn_rpld = rb(4'd3, 32'hDEADBEEF); dn_rlast = 1'b1;
        check("t1_rready", 64'(dn_rready), 64'd1);
        tick();
        dn_rvalid = 1'b0; dn_rlast = 1'b0;
        check("t1_up_rvalid", 64'(up_rvalid), 64'd1);
        check("t1_up_rpld", 64'(up_rpld), 64'(rb(4'd3, 32'hDEADBEEF)));
        check("t1_up_rlast", 64'(up_rlast), 64'd1);
        check("t1_ost_after_r", 64'(ost_cnt), 64'd0);
        tick();
        check("t1_up_rvalid_drop", 64'(up_rvalid), 64'd0);

        // reset with two beats buffered on each channel
        dn_arready = 1'b0; up_rready = 1'b0;
        up_arvalid = 1'b1; up_arpld = ar(4'd1, 32'h200, 8'd1);
        tick();
        up_arpld = ar(4'd2, 32'h300, 8'd1);
        tick();
        up_arvalid = 1'b0;
        dn_rvalid = 1'b1; dn_rpld = rb(4'd1, 32'h11);
        tick();
        dn_rpld = rb(4'd1, 32'h22);
        tick();
        dn_rvalid = 1'b0;
        check("rs_pre_arready", 64'(up_arready), 64'd0);
        check("rs_pre_rready", 64'(dn_rready), 64'd0);
        check("rs_pre_dn_arvalid", 64'(dn_arvalid), 64'd1);
        check("rs_pre_up_rvalid", 64'(up_rvalid), 64'd1);
`ifdef EASYAXI_RD_SLICE_OST_LIMIT_EN
        check("rs_pre_ost", 64'(ost_cnt), 64'd2);
`endif
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rs_dn_arvalid", 64'(dn_arvalid), 64'd0);
        check("rs_up_rvalid", 64'(up_rvalid), 64'd0);
        check("rs_ost", 64'(ost_cnt), 64'd0);
        check("rs_arready", 64'(up_arready), 64'd1);
        check("rs_rready", 64'(dn_rready), 64'd1);
        dn_arready = 1'b1; up_rready = 1'b1;
        tick();
        check("rs_post_dn_arvalid", 64'(dn_arvalid), 64'd0);
        check("rs_post_up_rvalid", 64'(up_rvalid), 64'd0);

`ifdef EASYAXI_RD_SLICE_OST_LIMIT_EN
        // limiter: MAX_OST=2
        up_arvalid = 1'b1; up_arpld = ar(4'd7, 32'h700, 8'd0);
        tick();
        up_arpld = ar(4'd8, 32'h800, 8'd0);
        tick();
        up_arpld = ar(4'd9, 32'h900, 8'd0);
        check("lim_ost2", 64'(ost_cnt), 64'd2);
        check("lim_arready_low", 64'(up_arready), 64'd0);
        tick();
        check("lim_ost_hold", 64'(ost_cnt), 64'd2);
        check("lim_arready_hold", 64'(up_arready), 64'd0);
        dn_rvalid = 1'b1; dn_rpld = rb(4'd7, 32'h77); dn_rlast = 1'b1;
        tick();
        dn_rvalid = 1'b0; dn_rlast = 1'b0;
        check("lim_ost1", 64'(ost_cnt), 64'd1);
        check("lim_arready_back", 64'(up_arready), 64'd1);
        tick();
        up_arvalid = 1'b0;
        check("lim_ost_back2", 64'(ost_cnt), 64'd2);
        check("lim_third_ar", 64'(dn_arpld), 64'(ar(4'd9, 32'h900, 8'd0)));
        tick();
`else
        // 16 back-to-back ARs
        for (int i = 0; i < 16; i++) begin
            up_arvalid = 1'b1; up_arpld = ar(4'(i), 32'(i * 16), 8'd0);
            check("st_arready", 64'(up_arready), 64'd1);
            tick();
            check("st_dn_arvalid", 64'(dn_arvalid), 64'd1);
            check("st_dn_arpld", 64'(dn_arpld), 64'(ar(4'(i), 32'(i * 16), 8'd0)));
        end
        up_arvalid = 1'b0;
        tick();
        check("st_drain", 64'(dn_arvalid), 64'd0);

        // backpressure: 3 ARs against a stalled slave
        dn_arready = 1'b0;
        up_arvalid = 1'b1; up_arpld = ar(4'd10, 32'hA00, 8'd0);
        tick();
        up_arpld = ar(4'd11, 32'hB00, 8'd0);
        check("bp_ready2", 64'(up_arready), 64'd1);
        tick();
        up_arpld = ar(4'd12, 32'hC00, 8'd0);
        check("bp_ready_low", 64'(up_arready), 64'd0);
        tick();
        check("bp_ready_low2", 64'(up_arready), 64'd0);
        check("bp_main_held", 64'(dn_arpld), 64'(ar(4'd10, 32'hA00, 8'd0)));
        dn_arready = 1'b1;
        tick();
        check("bp_second", 64'(dn_arpld), 64'(ar(4'd11, 32'hB00, 8'd0)));
        check("bp_ready_back", 64'(up_arready), 64'd1);
        tick();
        up_arvalid = 1'b0;
        check("bp_third", 64'(dn_arpld), 64'(ar(4'd12, 32'hC00, 8'd0)));
        tick();
        check("bp_drain", 64'(dn_arvalid), 64'd0);

        // 4-beat R burst with master stalls
        begin
            logic [6:0]    pat;
            logic [RW-1:0] hold;
            int s, d;
            logic ihs, stall;
            pat = 7'b1011001; // LSB first: 1,0,0,1,1,0,1
            s = 0; d = 0;
            for (int c = 0; c < 20; c++) begin
                dn_rvalid = (s < 4);
                dn_rpld   = rb(4'd5, 32'hA000_0000 + 32'(s));
                dn_rlast  = (s == 3);
                up_rready = (c < 7) ? pat[c] : 1'b1;
                ihs   = dn_rvalid & dn_rready;
                stall = up_rvalid & ~up_rready;
                hold  = up_rpld;
                if (up_rvalid && up_rready) begin
                    check("rb_pld", 64'(up_rpld), 64'(rb(4'd5, 32'hA000_0000 + 32'(d))));
                    check("rb_last", 64'(up_rlast), 64'(d == 3));
                    d++;
                end
                tick();
                if (ihs) s++;
                if (stall) check("rb_stable", 64'(up_rpld), 64'(hold));
            end
            dn_rvalid = 1'b0; dn_rlast = 1'b0;
            check("rb_beats_sent", 64'(s), 64'd4);
            check("rb_beats_recv", 64'(d), 64'd4);
            check("rb_idle", 64'(up_rvalid), 64'd0);
            check("rb_ost", 64'(ost_cnt), 64'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/easyaxi_rd_slice.md
Name: easyaxi_rd_slice

Overview:
- Registered read-path pipeline stage inserted in the link wiring between the master read controller and the slave read controller.
- Breaks every combinational path on the AR and R channels with a 2-entry skid buffer per channel, so full throughput is kept.
- Optionally limits outstanding read bursts in flight to the slave.

Parameters:
- MAX_OST, 8, max outstanding AR bursts (legal 1..255); used only with the optional feature.
- OST_W, $clog2(MAX_OST+1), width of the outstanding counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- up_arvalid  in  1  AR valid from master side
- up_arready  out  1  AR ready to master side
- up_arpld  in  ARW  {arid,araddr,arlen,arsize,arburst,aruser}; ARW = `AXI_ID_W+`AXI_ADDR_W+`AXI_LEN_W+`AXI_SIZE_W+`AXI_BURST_W+`AXI_USER_W
- dn_arvalid  out  1  AR valid to slave side
- dn_arready  in  1  AR ready from slave side
- dn_arpld  out  ARW  AR payload to slave side
- dn_rvalid  in  1  R valid from slave side
- dn_rready  out  1  R ready to slave side
- dn_rpld  in  RW  {rid,rdata,rresp,ruser}; RW = `AXI_ID_W+`AXI_DATA_W+`AXI_RESP_W+`AXI_USER_W
- dn_rlast  in  1  R last from slave side
- up_rvalid  out  1  R valid to master side
- up_rready  in  1  R ready from master side
- up_rpld  out  RW  R payload to master side
- up_rlast  out  1  R last to master side
- ost_cnt  out  OST_W  outstanding burst count

Behaviour:
- Single clock `clk`; reset `rst_n` is synchronous, active-low. Everything samples on the rising edge of clk.
- Reset values: dn_arvalid=0, up_rvalid=0, all payload/last registers=0, skid-full flags=0, ost_cnt=0, up_arready=1, dn_rready=1.
- Each channel (AR forward, R backward) uses an identical skid buffer: main register (drives the output) plus skid register.
  - Output valid = main valid.
  - Input ready = registered !skid_full.
  - No combinational path from any input to any output valid, ready or payload.
- Skid buffer per cycle, with in_hs = in_valid & in_ready and out_hs = out_valid & out_ready:
  - Main empty, or out_hs with skid empty: main loads the input if in_hs.
  - out_hs with skid full: main loads the skid; skid loads the input if in_hs, else skid empties.
  - in_hs while main holds data and no out_hs: skid captures; skid_full=1, so in_ready=0 next cycle.
  - Simultaneous in_hs and out_hs with main full and skid empty: main loads the input, throughput 1/cycle.
- Latency: 1 cycle from in_hs to out_valid when empty. Sustained rate 1 beat/cycle with both sides ready.
- AXI rules:
  - Output valid, once high, stays high with payload stable until out_hs.
  - Order is preserved. Beats are never dropped or duplicated.
  - rlast travels with its beat.
- up_arready = !ar_skid_full, additionally ANDed with the limiter term when the feature is enabled.
- Reset mid-burst: all buffered beats are discarded and ost_cnt returns to 0; the surrounding controllers are reset by the same rst_n.

Optional Feature:
- Macro EASYAXI_RD_SLICE_OST_LIMIT_EN.
- Defined:
  - ost_cnt increments on each upstream AR handshake and decrements on each downstream R handshake with dn_rlast=1.
  - Both events in the same cycle leave ost_cnt unchanged.
  - up_arready additionally requires ost_cnt < MAX_OST (compare on the registered count); ost_cnt never exceeds MAX_OST.
  - A decrement when ost_cnt=0 is a protocol error: flagged by an assertion, counter saturates at 0.
- Undefined: no counter logic, ost_cnt tied to 0, up_arready = !ar_skid_full only.

Test Plan:
- Single AR {arid=3,araddr=0x100,arlen=0}, dn_arready=1 -> dn_arvalid high exactly 1 cycle after up handshake, dn_arpld matches bit-exact; then 1 R beat rid=3, rlast=1 -> up_rvalid 1 cycle later, payload exact.
- Stream 16 ARs back-to-back with dn_arready=1 -> 16 dn handshakes on 16 consecutive cycles, in order, up_arready never low.
- Hold dn_arready=0 while issuing 3 ARs -> 2 captured (main+skid), up_arready low from the cycle after the 2nd; release -> all 3 delivered in order, none lost.
- R burst arlen=3 with up_rready toggling 1,0,0,1,1,0,1 -> exactly 4 beats delivered, rlast only on the 4th, payload stable while stalled.
- With EASYAXI_RD_SLICE_OST_LIMIT_EN, MAX_OST=2: issue 3 ARs, no R -> ost_cnt=2, up_arready low; one R with rlast -> ost_cnt=1, third AR accepted, ost_cnt=2.
- Assert rst_n=0 for 1 cycle with 2 beats buffered on each channel -> next cycle dn_arvalid=0, up_rvalid=0, ost_cnt=0, up_arready=1, dn_rready=1.
